// File: rtl/pid_cfg_writer.sv
// Bus-mapped shadow/active register bank feeding pid_controller gains and setpoint (ref_val).
// Optional setpoint slew limiter is compiled in with PID_CFG_RAMP_EN.
module pid_cfg_writer #(
   parameter int unsigned COEFF_WIDTH     = 32,
   parameter int unsigned IN_DATA_WIDTH   = 16,
   parameter int unsigned ADDR_WIDTH      = 8,
   parameter int unsigned RAMP_STEP_WIDTH = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            wr_en,
   input  logic                            rd_en,
   input  logic [ADDR_WIDTH-1:0]           addr,
   input  logic [31:0]                     wdata,
   output logic [31:0]                     rdata,
   output logic                            ack,
   input  logic                            upd_tick,
   output logic signed [COEFF_WIDTH-1:0]   kp,
   output logic signed [COEFF_WIDTH-1:0]   ki,
   output logic signed [COEFF_WIDTH-1:0]   kd,
   output logic signed [IN_DATA_WIDTH-1:0] ref_val,
   output logic                            pid_rst,
   output logic                            busy
);

   localparam int unsigned WW = ADDR_WIDTH - 2;
   localparam logic [WW-1:0] A_KP     = WW'(0);
   localparam logic [WW-1:0] A_KI     = WW'(1);
   localparam logic [WW-1:0] A_KD     = WW'(2);
   localparam logic [WW-1:0] A_REF    = WW'(3);
   localparam logic [WW-1:0] A_CTRL   = WW'(4);
   localparam logic [WW-1:0] A_STATUS = WW'(5);
   localparam logic [WW-1:0] A_STEP   = WW'(6);

`ifdef PID_CFG_RAMP_EN
   typedef enum logic [1:0] {IDLE, PENDING, RAMP} state_t;
`else
   typedef enum logic [1:0] {IDLE, PENDING} state_t;
`endif

   state_t state, state_nxt;

   logic signed [COEFF_WIDTH-1:0]   kp_sh, ki_sh, kd_sh;
   logic signed [IN_DATA_WIDTH-1:0] ref_tgt;
   logic [WW-1:0] word;
   logic          ctrl_wr, commit, apply;
   logic [31:0]   rd_mux;

   assign word    = WW'(addr >> 2);
   assign ctrl_wr = wr_en && (word == A_CTRL);
   assign commit  = ctrl_wr && wdata[0];

`ifdef PID_CFG_RAMP_EN
   localparam int unsigned DW = IN_DATA_WIDTH + 1;
   localparam int unsigned CW = (DW > RAMP_STEP_WIDTH) ? DW : RAMP_STEP_WIDTH;

   logic [RAMP_STEP_WIDTH-1:0]      ramp_step;
   logic signed [IN_DATA_WIDTH-1:0] tgt_act, ramp_ref;
   logic signed [DW-1:0]            diff;
   logic [DW-1:0]                   mag;
   logic signed [CW:0]              ext_ref, step_s, stepped;
   logic                            close, ramp_req, step_en;

   // One slew step toward the latched target; snaps when within one step.
   always_comb begin
      diff     = DW'(tgt_act) - DW'(ref_val);
      mag      = diff[DW-1] ? DW'(-diff) : DW'(diff);
      close    = CW'(mag) <= CW'(ramp_step);
      ext_ref  = (CW+1)'(ref_val);
      step_s   = (CW+1)'(ramp_step);
      stepped  = diff[DW-1] ? (ext_ref - step_s) : (ext_ref + step_s);
      ramp_ref = close ? tgt_act : IN_DATA_WIDTH'(stepped);
      ramp_req = (ramp_step != '0) && (ref_tgt != ref_val);
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      apply     = 1'b0;
`ifdef PID_CFG_RAMP_EN
      step_en   = 1'b0;
`endif
      case (state)
         IDLE:    if (commit) state_nxt = PENDING;
         PENDING: if (upd_tick) begin
            apply = 1'b1;
`ifdef PID_CFG_RAMP_EN
            state_nxt = ramp_req ? RAMP : IDLE;
`else
            state_nxt = IDLE;
`endif
         end
`ifdef PID_CFG_RAMP_EN
         // A new commit pauses the ramp where it is and waits for the next tick.
         RAMP: begin
            if (commit) state_nxt = PENDING;
            else if (upd_tick) begin
               step_en = 1'b1;
               if (close) state_nxt = IDLE;
            end
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      rd_mux = '0;
      case (word)
         A_KP:     rd_mux = 32'(kp_sh);
         A_KI:     rd_mux = 32'(ki_sh);
         A_KD:     rd_mux = 32'(kd_sh);
         A_REF:    rd_mux = 32'(ref_tgt);
`ifdef PID_CFG_RAMP_EN
         A_STATUS: rd_mux = {30'd0, state == RAMP, state == PENDING};
         A_STEP:   rd_mux = 32'(ramp_step);
`else
         A_STATUS: rd_mux = {31'd0, state == PENDING};
`endif
         default:  rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         kp_sh <= '0; ki_sh <= '0; kd_sh <= '0; ref_tgt <= '0;
         kp <= '0; ki <= '0; kd <= '0; ref_val <= '0;
         rdata <= '0; ack <= 1'b0; pid_rst <= 1'b0; busy <= 1'b0;
`ifdef PID_CFG_RAMP_EN
         ramp_step <= '0; tgt_act <= '0;
`endif
      end else begin
         ack     <= wr_en | rd_en;
         rdata   <= (rd_en && !wr_en) ? rd_mux : '0;
         pid_rst <= ctrl_wr && wdata[1];
         busy    <= (state_nxt != IDLE);
         if (wr_en) begin
            case (word)
               A_KP:    kp_sh   <= COEFF_WIDTH'(wdata);
               A_KI:    ki_sh   <= COEFF_WIDTH'(wdata);
               A_KD:    kd_sh   <= COEFF_WIDTH'(wdata);
               A_REF:   ref_tgt <= IN_DATA_WIDTH'(wdata);
`ifdef PID_CFG_RAMP_EN
               A_STEP:  ramp_step <= RAMP_STEP_WIDTH'(wdata);
`endif
               default: ;
            endcase
         end
         // Atomic apply uses the shadow contents as they stand before this edge.
         if (apply) begin
            kp <= kp_sh; ki <= ki_sh; kd <= kd_sh;
`ifdef PID_CFG_RAMP_EN
            tgt_act <= ref_tgt;
            if (!ramp_req) ref_val <= ref_tgt;
`else
            ref_val <= ref_tgt;
`endif
         end
`ifdef PID_CFG_RAMP_EN
         if (step_en) ref_val <= ramp_ref;
`endif
      end
   end

endmodule

// File: tb/tb_pid_cfg_writer.sv
// Self-checking bench for pid_cfg_writer: register table, directed corner sequences,
// and randomized traffic against a cycle-level behavioural model.
module tb_pid_cfg_writer;

`ifdef PID_CFG_RAMP_EN
   localparam bit RAMP = 1'b1;
`else
   localparam bit RAMP = 1'b0;
`endif

   logic clk, rst, wr_en, rd_en, upd_tick, ack, pid_rst, busy;
   logic [7:0]  addr;
   logic [31:0] wdata, rdata;
   logic signed [31:0] kp, ki, kd;
   logic signed [15:0] ref_val;

   int errors = 0;
   int checks = 0;

   pid_cfg_writer dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wdata(wdata),
      .rdata(rdata), .ack(ack), .upd_tick(upd_tick), .kp(kp), .ki(ki), .kd(kd),
      .ref_val(ref_val), .pid_rst(pid_rst), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model state
   int m_skp, m_ski, m_skd, m_sref, m_step, m_kp, m_ki, m_kd, m_ref, m_tgt;
   bit m_pend, m_ramp, m_ack, m_prst;
   logic [31:0] m_rdata;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int sx16(input logic [31:0] v);
      shortint s;
      s = v[15:0];
      return int'(s);
   endfunction

   function automatic logic [31:0] model_read(input int w);
      case (w)
         0: return m_skp;
         1: return m_ski;
         2: return m_skd;
         3: return m_sref;
         5: return {30'd0, m_ramp, m_pend};
         6: return m_step;
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_reset();
      m_skp = 0; m_ski = 0; m_skd = 0; m_sref = 0; m_step = 0;
      m_kp = 0; m_ki = 0; m_kd = 0; m_ref = 0; m_tgt = 0;
      m_pend = 0; m_ramp = 0; m_ack = 0; m_prst = 0; m_rdata = 0;
   endtask

   // Advance the model by one clock using the inputs currently driven.
   task automatic model_step();
      int  w, d, mag;
      bit  commit;
      w      = int'(addr >> 2);
      commit = wr_en && (w == 4) && wdata[0];
      m_ack   = wr_en || rd_en;
      m_rdata = (rd_en && !wr_en) ? model_read(w) : 32'd0;
      m_prst  = wr_en && (w == 4) && wdata[1];
      if (m_pend) begin
         if (upd_tick) begin
            m_kp = m_skp; m_ki = m_ski; m_kd = m_skd; m_tgt = m_sref;
            m_pend = 0;
            if (m_step != 0 && m_sref != m_ref) m_ramp = 1;
            else m_ref = m_sref;
         end
      end else if (m_ramp) begin
         if (commit) begin
            m_ramp = 0; m_pend = 1;
         end else if (upd_tick) begin
            d   = m_tgt - m_ref;
            mag = (d < 0) ? -d : d;
            if (mag <= m_step) begin
               m_ref = m_tgt; m_ramp = 0;
            end else m_ref = m_ref + ((d < 0) ? -m_step : m_step);
         end
      end else if (commit) m_pend = 1;
      if (wr_en) begin
         case (w)
            0: m_skp = wdata;
            1: m_ski = wdata;
            2: m_skd = wdata;
            3: m_sref = sx16(wdata);
            6: m_step = RAMP ? int'(wdata[15:0]) : 0;
            default: ;
         endcase
      end
   endtask

   task automatic compare_all();
      check("ack", 32'(ack), 32'(m_ack));
      check("rdata", rdata, m_rdata);
      check("kp", kp, m_kp);
      check("ki", ki, m_ki);
      check("kd", kd, m_kd);
      check("ref", 32'(ref_val), m_ref);
      check("pid_rst", 32'(pid_rst), 32'(m_prst));
      check("busy", 32'(busy), 32'(m_pend | m_ramp));
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      wr_en = 1'b1; addr = a; wdata = d;
      cycle();
      wr_en = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, output logic [31:0] d);
      rd_en = 1'b1; addr = a;
      cycle();
      d = rdata;
      rd_en = 1'b0;
   endtask

   task automatic tick();
      upd_tick = 1'b1;
      cycle();
      upd_tick = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   // Assert reset between edges; outputs must clear without a clock edge.
   task automatic async_reset(input string tag);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check({tag, "_kp"}, kp, 0);
      check({tag, "_ki"}, ki, 0);
      check({tag, "_kd"}, kd, 0);
      check({tag, "_ref"}, 32'(ref_val), 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_ack"}, 32'(ack), 0);
      check({tag, "_rdata"}, rdata, 0);
      check({tag, "_pid_rst"}, 32'(pid_rst), 0);
      model_reset();
      #1 rst = 1'b0;
   endtask

   typedef struct {
      logic [7:0]  a;
      logic [31:0] w;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl[10];
   logic [31:0] got;
   logic [7:0] amap[8];

   initial begin
      rst = 1'b1; wr_en = 0; rd_en = 0; upd_tick = 0; addr = '0; wdata = '0;
      model_reset();
      #2;
      check("por_kp", kp, 0);
      check("por_ref", 32'(ref_val), 0);
      check("por_busy", 32'(busy), 0);
      @(posedge clk); #1 rst = 1'b0;

      tbl[0] = '{8'h00, 32'h1234_5678, 32'h1234_5678};
      tbl[1] = '{8'h04, 32'hFFFF_FFFD, 32'hFFFF_FFFD};
      tbl[2] = '{8'h08, 32'h8000_0000, 32'h8000_0000};
      tbl[3] = '{8'h0C, 32'h0001_8000, 32'hFFFF_8000};
      tbl[4] = '{8'h0C, 32'h0000_7FFF, 32'h0000_7FFF};
      tbl[5] = '{8'h10, 32'h0000_0000, 32'h0000_0000};
      tbl[6] = '{8'h14, 32'h0000_0003, 32'h0000_0000};
      tbl[7] = '{8'h18, 32'h0001_2345, RAMP ? 32'h0000_2345 : 32'h0};
      tbl[8] = '{8'h40, 32'h0000_DEAD, 32'h0000_0000};
      tbl[9] = '{8'h05, 32'h0000_0009, 32'h0000_0009};
      for (int i = 0; i < 10; i++) begin
         wr(tbl[i].a, tbl[i].w);
         rd(tbl[i].a, got);
         check($sformatf("tbl%0d", i), got, tbl[i].exp);
      end

      async_reset("rst_idle");
      rd(8'h00, got);
      check("rst_shadow", got, 0);

      // Gains apply only on the tick after commit
      wr(8'h00, 5); wr(8'h04, 32'hFFFF_FFFD); wr(8'h08, 7); wr(8'h10, 1);
      idle(4);
      check("t1_kp_hold", kp, 0);
      check("t1_busy_pend", 32'(busy), 1);
      tick();
      check("t1_kp", kp, 5);
      check("t1_ki", ki, 32'hFFFF_FFFD);
      check("t1_kd", kd, 7);
      check("t1_busy", 32'(busy), 0);

      rd(8'h04, got);
      check("t2_ack", 32'(ack), 1);
      check("t2_rdata", got, 32'hFFFF_FFFD);
      idle(1);
      check("t2_ack_drop", 32'(ack), 0);
      rd(8'h40, got);
      check("t2_unmapped", got, 0);

      // Commit coincident with tick defers the apply; repeated commit applies once
      wr(8'h00, 11);
      wr_en = 1; addr = 8'h10; wdata = 1; upd_tick = 1;
      cycle();
      wr_en = 0; upd_tick = 0;
      check("t4_no_apply", kp, 5);
      wr(8'h10, 1);
      tick();
      check("t4_apply", kp, 11);
      wr(8'h00, 12);
      tick();
      check("t4_single", kp, 11);
      check("t4_busy", 32'(busy), 0);

      wr(8'h10, 2);
      check("t5_pid_rst", 32'(pid_rst), 1);
      idle(1);
      check("t5_pid_rst_pulse", 32'(pid_rst), 0);
      check("t5_kp", kp, 11);
      wr_en = 1; rd_en = 1; addr = 8'h08; wdata = 99;
      cycle();
      wr_en = 0; rd_en = 0;
      check("t5_both_ack", 32'(ack), 1);
      check("t5_both_rdata", rdata, 0);
      rd(8'h08, got);
      check("t5_both_wr", got, 99);

`ifdef PID_CFG_RAMP_EN
      begin
         int seq[4] = '{300, 600, 900, 1000};
         wr(8'h18, 300); wr(8'h0C, 1000); wr(8'h10, 1);
         tick();
         check("t3_apply_ref", 32'(ref_val), 0);
         rd(8'h14, got);
         check("t3_status", got, 2);
         for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("t3_ref%0d", i), 32'(ref_val), seq[i]);
         end
         check("t3_idle", 32'(busy), 0);
         wr(8'h0C, 32'hFFFF_8000); wr(8'h10, 1);
         tick();
         for (int i = 0; i < 200 && busy; i++) tick();
         check("t3_neg_end", 32'(ref_val), 32'hFFFF_8000);
         check("t3_neg_idle", 32'(busy), 0);
      end
      wr(8'h18, 0); wr(8'h0C, 0); wr(8'h10, 1); tick();
      check("t6_zeroed", 32'(ref_val), 0);
      wr(8'h18, 300); wr(8'h0C, 1000); wr(8'h10, 1);
      tick(); tick(); tick();
      check("t6_mid", 32'(ref_val), 600);
      async_reset("t6_rst");
`else
      wr(8'h00, 3); wr(8'h10, 1);
      async_reset("t6_rst");
`endif
      wr(8'h10, 1);
      tick();
      check("t6_ref", 32'(ref_val), 0);
      check("t6_kp", kp, 0);
      check("t6_busy", 32'(busy), 0);

      amap = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h40};
      for (int n = 0; n < 600; n++) begin
         wr_en    = ($urandom % 4) == 0;
         rd_en    = ($urandom % 4) == 0;
         upd_tick = ($urandom % 3) == 0;
         addr     = amap[$urandom % 8] | 8'($urandom % 4);
         case (addr >> 2)
            8'd3:    wdata = $urandom_range(0, 65535);
            8'd4:    wdata = $urandom % 4;
            8'd6:    wdata = $urandom_range(0, 9000);
            default: wdata = $urandom;
         endcase
         cycle();
      end
      wr_en = 0; rd_en = 0; upd_tick = 0;
      idle(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
